systolic_grid_rect: RTL and testbench

- Parametrised successor to the square systolic grid: ROWS x COLS output-stationary MAC array with built-in input skew, a run-time reduction depth K, and a flow-controlled drain of C.
- Sits between the A/B tile shift registers and the C writeback path.
- The controller FSM sequences accumulation, wavefront flush and backpressured row-by-row drain.
- Arithmetic is signed integer MAC, replacing the fixed float PE.

---
 rtl/systolic_grid_pkg.sv | 45 ++++
 rtl/systolic_mac_pe.sv | 80 ++++++++
 rtl/systolic_grid_rect.sv | 228 ++++++++++++++++++++++
 tb/tb_systolic_grid_rect.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_grid_pkg.sv
// Shared types and arithmetic helpers for the rectangular systolic MAC grid.
// The accumulator helpers cover both builds; SYSTOLIC_GRID_SATURATE_EN picks acc_sat.
package systolic_grid_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StFlush,
    StDrain
  } state_e;

  // Working width for one accumulate step; ACC_WIDTH must stay below this.
  localparam int unsigned MaxAccW = 64;
  typedef logic signed [MaxAccW-1:0] wide_t;

  function automatic int unsigned cnt_width(input int unsigned max_k);
    return $clog2(max_k + 1);
  endfunction

  // Two's-complement wrap of sum to width bits, returned sign-extended.
  function automatic wide_t acc_wrap(input wide_t sum, input int unsigned width);
    wide_t shl;
    shl = sum <<< (MaxAccW - width);
    return shl >>> (MaxAccW - width);
  endfunction

  // Clamp sum to the signed range of width bits; clip flags a clamped result.
  function automatic wide_t acc_sat(input wide_t sum, input int unsigned width,
                                    output logic clip);
    wide_t hi, lo, res;
    hi   = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo   = -hi - wide_t'(1);
    res  = sum;
    clip = 1'b0;
    if (sum > hi) begin
      res  = hi;
      clip = 1'b1;
    end else if (sum < lo) begin
      res  = lo;
      clip = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// Output-stationary signed MAC cell: registers a/b for its neighbours, accumulates in place
// and shifts its accumulator down the column during drain. SYSTOLIC_GRID_SATURATE_EN adds clip_o.
module systolic_mac_pe
  import systolic_grid_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        advance_i,
  input  logic                        clear_i,
  input  logic                        shift_out_i,
  input  logic signed [A_WIDTH-1:0]   a_i,
  input  logic signed [B_WIDTH-1:0]   b_i,
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [A_WIDTH-1:0]   a_o,
  output logic signed [B_WIDTH-1:0]   b_o,
  output logic signed [ACC_WIDTH-1:0] acc_o
`ifdef SYSTOLIC_GRID_SATURATE_EN
  ,
  output logic                        clip_o
`endif
);

  logic signed [A_WIDTH-1:0]         a_q, a_d;
  logic signed [B_WIDTH-1:0]         b_q, b_d;
  logic signed [ACC_WIDTH-1:0]       acc_q, acc_d, acc_nxt;
  logic signed [A_WIDTH+B_WIDTH-1:0] prod;
  wide_t                             sum;

  assign prod = a_i * b_i;
  assign sum  = wide_t'(acc_q) + wide_t'(prod);

`ifdef SYSTOLIC_GRID_SATURATE_EN
  logic clip;
  always_comb begin
    clip    = 1'b0;
    acc_nxt = ACC_WIDTH'(acc_sat(sum, ACC_WIDTH, clip));
  end
  assign clip_o = advance_i & ~clear_i & clip;
`else
  assign acc_nxt = ACC_WIDTH'(acc_wrap(sum, ACC_WIDTH));
`endif

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clear_i) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (advance_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = acc_nxt;
    end else if (shift_out_i) begin
      acc_d = acc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_grid_rect.sv
// ROWS x COLS output-stationary signed MAC grid with input skew, run-time depth and
// backpressured bottom-row-first drain. SYSTOLIC_GRID_SATURATE_EN adds saturation + overflow.
module systolic_grid_rect
  import systolic_grid_pkg::*;
#(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned MAX_K     = 256
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [cnt_width(MAX_K)-1:0]    kLen,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic signed [A_WIDTH-1:0]      aIn [ROWS],
  input  logic signed [B_WIDTH-1:0]      bIn [COLS],
  output logic                           outValid,
  input  logic                           outReady,
  output logic signed [ACC_WIDTH-1:0]    cOut [COLS],
  output logic                           busy
`ifdef SYSTOLIC_GRID_SATURATE_EN
  ,
  output logic                           overflow
`endif
);

  localparam int unsigned FlushLen = ROWS + COLS - 2;
  localparam int unsigned CntW     = cnt_width(MAX_K) + cnt_width(ROWS + COLS);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              advance, clear, shift, inject;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    clear   = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clear = 1'b1;
          if (kLen != '0) begin
            state_d = StFeed;
            cnt_d   = CntW'(kLen);
          end else begin
            state_d = StDrain;
            cnt_d   = CntW'(ROWS);
          end
        end
      end
      StFeed: begin
        if (inValid) begin
          advance = 1'b1;
          cnt_d   = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            if (FlushLen == 0) begin
              state_d = StDrain;
              cnt_d   = CntW'(ROWS);
            end else begin
              state_d = StFlush;
              cnt_d   = CntW'(FlushLen);
            end
          end
        end
      end
      StFlush: begin
        advance = 1'b1;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDrain;
          cnt_d   = CntW'(ROWS);
        end
      end
      StDrain: begin
        if (outReady) begin
          shift = 1'b1;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Zeros enter the skew lines during flush so the wavefront drains cleanly.
  assign inject   = (state_q == StFeed);
  assign inReady  = (state_q == StFeed);
  assign outValid = (state_q == StDrain);
  assign busy     = (state_q != StIdle);

  logic signed [A_WIDTH-1:0]   a_bus   [ROWS][COLS];
  logic signed [B_WIDTH-1:0]   b_bus   [ROWS][COLS];
  logic signed [A_WIDTH-1:0]   a_out   [ROWS][COLS];
  logic signed [B_WIDTH-1:0]   b_out   [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] acc_out [ROWS][COLS];
  logic [ROWS*A_WIDTH-1:0]     a_edge_unused;
  logic [COLS*B_WIDTH-1:0]     b_edge_unused;

  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic signed [A_WIDTH-1:0] a_src;
    assign a_src = inject ? aIn[i] : '0;
    if (i == 0) begin : g_direct
      assign a_bus[i][0] = a_src;
    end else begin : g_delay
      logic signed [A_WIDTH-1:0] sk_q [i];
      logic signed [A_WIDTH-1:0] sk_d [i];
      always_comb begin
        sk_d = sk_q;
        if (clear) begin
          for (int s = 0; s < i; s++) sk_d[s] = '0;
        end else if (advance) begin
          sk_d[0] = a_src;
          for (int s = 1; s < i; s++) sk_d[s] = sk_q[s-1];
        end
      end
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < i; s++) sk_q[s] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end
      assign a_bus[i][0] = sk_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic signed [B_WIDTH-1:0] b_src;
    assign b_src = inject ? bIn[j] : '0;
    if (j == 0) begin : g_direct
      assign b_bus[0][j] = b_src;
    end else begin : g_delay
      logic signed [B_WIDTH-1:0] sk_q [j];
      logic signed [B_WIDTH-1:0] sk_d [j];
      always_comb begin
        sk_d = sk_q;
        if (clear) begin
          for (int s = 0; s < j; s++) sk_d[s] = '0;
        end else if (advance) begin
          sk_d[0] = b_src;
          for (int s = 1; s < j; s++) sk_d[s] = sk_q[s-1];
        end
      end
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < j; s++) sk_q[s] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end
      assign b_bus[0][j] = sk_q[j-1];
    end
  end

`ifdef SYSTOLIC_GRID_SATURATE_EN
  logic [ROWS*COLS-1:0] clip;
  logic                 overflow_q, overflow_d;
  always_comb begin
    overflow_d = overflow_q;
    if (clear)      overflow_d = 1'b0;
    else if (|clip) overflow_d = 1'b1;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end
  assign overflow = overflow_q;
`endif

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [ACC_WIDTH-1:0] acc_in;
      if (j > 0) begin : g_a_link
        assign a_bus[i][j] = a_out[i][j-1];
      end
      if (i > 0) begin : g_b_link
        assign b_bus[i][j] = b_out[i-1][j];
        assign acc_in      = acc_out[i-1][j];
      end else begin : g_top
        assign acc_in = '0;
      end
      systolic_mac_pe #(
        .A_WIDTH  (A_WIDTH),
        .B_WIDTH  (B_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
      ) u_pe (
        .clk_i      (clock),
        .rst_ni     (reset),
        .advance_i  (advance),
        .clear_i    (clear),
        .shift_out_i(shift),
        .a_i        (a_bus[i][j]),
        .b_i        (b_bus[i][j]),
        .acc_i      (acc_in),
        .a_o        (a_out[i][j]),
        .b_o        (b_out[i][j]),
        .acc_o      (acc_out[i][j])
`ifdef SYSTOLIC_GRID_SATURATE_EN
        ,
        .clip_o     (clip[i*COLS+j])
`endif
      );
    end
    assign a_edge_unused[i*A_WIDTH +: A_WIDTH] = a_out[i][COLS-1];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_cout
    assign cOut[j] = acc_out[ROWS-1][j];
    assign b_edge_unused[j*B_WIDTH +: B_WIDTH] = b_out[ROWS-1][j];
  end

endmodule

// File: tb/tb_systolic_grid_rect.sv
// Self-checking bench for systolic_grid_rect (2x2, 16-bit accumulators); a matrix-product
// model predicts every drained C row. Honours SYSTOLIC_GRID_SATURATE_EN.
module tb_systolic_grid_rect;

  localparam int unsigned R    = 2;
  localparam int unsigned C    = 2;
  localparam int unsigned AW   = 8;
  localparam int unsigned BW   = 8;
  localparam int unsigned ACCW = 16;
  localparam int unsigned MAXK = 256;
  localparam int unsigned KW   = $clog2(MAXK + 1);
  localparam int unsigned MAXT = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start;
  logic [KW-1:0]          kLen;
  logic                   inValid, inReady;
  logic signed [AW-1:0]   aIn [R];
  logic signed [BW-1:0]   bIn [C];
  logic                   outValid, outReady;
  logic signed [ACCW-1:0] cOut [C];
  logic                   busy;
`ifdef SYSTOLIC_GRID_SATURATE_EN
  logic                   overflow;
`endif

  systolic_grid_rect #(
    .ROWS(R), .COLS(C), .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACCW), .MAX_K(MAXK)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .kLen    (kLen),
    .inValid (inValid),
    .inReady (inReady),
    .aIn     (aIn),
    .bIn     (bIn),
    .outValid(outValid),
    .outReady(outReady),
    .cOut    (cOut),
    .busy    (busy)
`ifdef SYSTOLIC_GRID_SATURATE_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clock = ~clock;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  longint start_cyc, first_cyc;
  bit     first_seen;
  bit     exp_ovf;
  int     hs;
  longint exp_q[$];
  longint got_q[$];
  int     a_mat [R][MAXT];
  int     b_mat [MAXT][C];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // C = A x B with each accumulate step wrapped or clamped to ACCW bits; bottom row first.
  task automatic model_tile(input int k);
    longint lim, mask, s;
    lim  = longint'(1) <<< (ACCW - 1);
    mask = (longint'(1) <<< ACCW) - 1;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int r = R - 1; r >= 0; r--) begin
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int t = 0; t < k; t++) begin
          s = s + longint'(a_mat[r][t]) * longint'(b_mat[t][j]);
`ifdef SYSTOLIC_GRID_SATURATE_EN
          if (s > lim - 1) begin s = lim - 1; exp_ovf = 1'b1; end
          else if (s < -lim) begin s = -lim; exp_ovf = 1'b1; end
`else
          s = s & mask;
          if (s >= lim) s = s - 2 * lim;
`endif
        end
        exp_q.push_back(s);
      end
    end
  endtask

  // Compare process: every drained row is checked against the model.
  always @(negedge clock) begin
    if (reset) begin
      check("inready_outside_feed", longint'(inReady && (!busy || outValid)), 0);
      if (outValid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          first_cyc  = cyc;
        end
        if (exp_q.size() >= C) begin
          for (int j = 0; j < C; j++) check("c_row", longint'(cOut[j]), exp_q[j]);
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_row: got outValid=1, expected no further rows");
        end
`ifdef SYSTOLIC_GRID_SATURATE_EN
        check("overflow", longint'(overflow), longint'(exp_ovf));
`endif
        if (outReady) begin
          for (int j = 0; j < C; j++) got_q.push_back(longint'(cOut[j]));
          for (int j = 0; j < C; j++) if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs++;
        end
      end
    end
  end

  task automatic drive_beat(input bit live, input int t);
    for (int i = 0; i < R; i++) aIn[i] = live ? AW'(a_mat[i][t]) : AW'(99 + i);
    for (int j = 0; j < C; j++) bIn[j] = live ? BW'(b_mat[t][j]) : BW'(77 - j);
  endtask

  task automatic run_tile(input int k, input bit gaps, input bit stall, input bit restart);
    int t = 0, n = 0, rdy_cnt = 0, stall_cnt = 0;
    bit took;
    model_tile(k);
    got_q.delete();
    hs         = 0;
    first_seen = 1'b0;
    start_cyc  = cyc;
    while (!(hs == R && !busy) && n < 200) begin
      start    = (n == 0) || (restart && n == 1);
      kLen     = (n == 0) ? KW'(k) : KW'(1);
      inValid  = gaps ? (n % 2 == 1) : 1'b1;
      drive_beat(inValid && t < k, (t < k) ? t : 0);
      outReady = !(stall && hs == 1 && stall_cnt < 3);
      if (!outReady) stall_cnt++;
      took = inValid && inReady;
      if (inReady) rdy_cnt++;
      @(posedge clock);
      #1;
      if (!outReady) check("stall_holds_valid", longint'(outValid), 1);
      if (took) t++;
      n++;
    end
    start    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    check("tile_within_budget", longint'(n < 200), 1);
    check("beats_accepted", t, k);
    check("inready_cycles", rdy_cnt, gaps ? (k > 0 ? 2 * k - 1 : 0) : k);
    check("handshakes", hs, R);
    check("busy_after_drain", longint'(busy), 0);
    if (!gaps) check("first_row_latency", first_cyc - start_cyc, (k == 0) ? 1 : k + R + C - 1);
    repeat (2) @(posedge clock);
    #1;
    check("stays_idle", longint'(busy || outValid), 0);
  endtask

  task automatic check_rows(input string tag, input longint e0, input longint e1,
                            input longint e2, input longint e3);
    longint e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++)
      check(tag, (got_q.size() > i) ? got_q[i] : -999999, e[i]);
  endtask

  task automatic reset_in_flush();
    int t = 0, guard = 0;
    bit took;
    start = 1'b1;
    kLen  = KW'(2);
    @(posedge clock);
    #1;
    start = 1'b0;
    while (t < 2 && guard < 20) begin
      inValid = 1'b1;
      drive_beat(1'b1, t);
      took = inReady;
      @(posedge clock);
      #1;
      if (took) t++;
      guard++;
    end
    inValid = 1'b0;
    check("reached_flush", longint'(busy && !inReady && !outValid), 1);
    reset = 1'b0;
    #1;
    check("rst_inready", longint'(inReady), 0);
    check("rst_outvalid", longint'(outValid), 0);
    check("rst_busy", longint'(busy), 0);
    for (int j = 0; j < C; j++) check("rst_cout", longint'(cOut[j]), 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    kLen     = '0;
    inValid  = 1'b0;
    outReady = 1'b1;
    drive_beat(1'b0, 0);
    #2;
    check("reset_inready", longint'(inReady), 0);
    check("reset_outvalid", longint'(outValid), 0);
    check("reset_busy", longint'(busy), 0);
    for (int j = 0; j < C; j++) check("reset_cout", longint'(cOut[j]), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    a_mat = '{'{1, 2, 0, 0}, '{3, 4, 0, 0}};
    b_mat = '{'{5, 6}, '{7, 8}, '{0, 0}, '{0, 0}};
    run_tile(2, 1'b0, 1'b0, 1'b0);
    check_rows("basic_rows", 43, 50, 19, 22);
    run_tile(2, 1'b1, 1'b0, 1'b0);
    check_rows("gapped_rows", 43, 50, 19, 22);
    run_tile(2, 1'b0, 1'b1, 1'b0);
    check_rows("stalled_rows", 43, 50, 19, 22);

    run_tile(0, 1'b0, 1'b0, 1'b1);
    check_rows("klen0_rows", 0, 0, 0, 0);

    reset_in_flush();
    a_mat = '{'{-3, 5, 0, 0}, '{2, -7, 0, 0}};
    b_mat = '{'{4, -1}, '{6, 9}, '{0, 0}, '{0, 0}};
    run_tile(2, 1'b0, 1'b0, 1'b0);
    check_rows("post_reset_rows", -34, -65, 18, 48);

    a_mat = '{'{-128, 127, -1, 0}, '{5, -6, 7, 0}};
    b_mat = '{'{-128, 3}, '{127, -4}, '{1, 100}, '{0, 0}};
    run_tile(3, 1'b0, 1'b0, 1'b0);
    check_rows("edge_rows", -1395, 739, 32512, -992);

    a_mat = '{'{127, 127, 127, 127}, '{127, 127, 127, 127}};
    b_mat = '{'{127, 127}, '{127, 127}, '{127, 127}, '{127, 127}};
    run_tile(4, 1'b0, 1'b0, 1'b0);
`ifdef SYSTOLIC_GRID_SATURATE_EN
    check_rows("sat_rows", 32767, 32767, 32767, 32767);
    check("sat_overflow_sticky", longint'(overflow), 1);
`else
    check_rows("wrap_rows", -1020, -1020, -1020, -1020);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
